// File: rtl/i2c_cfg_sequencer.sv
// Drives an I2C byte master: loads a sensor register table after reset, then serves host reads/writes.
// Define I2C_SCCB_STOP_EN to split reads with STOP+START instead of a repeated START.
module i2c_cfg_sequencer #(
   parameter logic [6:0]  DEV_ADDR   = 7'h21,
   parameter logic [15:0] INIT_DLY   = 16'd1000,
   parameter logic [15:0] SETTLE_CYC = 16'd100,
   parameter int          TBL_AW     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [2:0]        m_cmd,
   output logic [7:0]        m_din,
   output logic              m_wr,
   input  logic              m_ready,
   input  logic              m_done_tick,
   input  logic              m_ack,
   input  logic [7:0]        m_dout,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [15:0]       tbl_data,
   input  logic              req,
   input  logic              req_rw,
   input  logic [7:0]        req_reg,
   input  logic [7:0]        req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              init_done,
   output logic              init_err
);
   localparam logic [2:0] CMD_START   = 3'b000;
   localparam logic [2:0] CMD_WR      = 3'b001;
   localparam logic [2:0] CMD_RD      = 3'b010;
   localparam logic [2:0] CMD_STOP    = 3'b011;
   localparam logic [2:0] CMD_RESTART = 3'b100;
   localparam logic [2:0] WR_LAST     = 3'd4;
`ifdef I2C_SCCB_STOP_EN
   localparam logic [2:0] RD_LAST     = 3'd7;
`else
   localparam logic [2:0] RD_LAST     = 3'd6;
`endif

   typedef enum logic [2:0] {S_DLY, S_FETCH, S_FETCH_W, S_ISSUE, S_GUARD, S_WAIT, S_SETTLE, S_IDLE} state_t;
   state_t r_state, w_state_nxt;

   logic [15:0]       r_cnt;
   logic [2:0]        r_step;
   logic              r_host, r_rw, r_err, r_ack_cap;
   logic [7:0]        r_reg, r_val, r_rdata;
   logic [TBL_AW-1:0] r_tbl_addr;
   logic [2:0]        r_m_cmd;
   logic [7:0]        r_m_din, r_rsp_rdata;
   logic              r_m_wr, r_rsp_valid, r_rsp_err, r_init_done, r_init_err;
   logic [10:0]       w_step_word;
   logic [2:0]        w_last;
   logic              w_is_wr, w_is_rd, w_nack_now, w_settle_done, w_dly_done, w_tbl_end, w_sentinel;

   // {cmd, byte} for a given step of a write (rw=0) or read (rw=1) transaction.
   function automatic logic [10:0] step_word(input logic rw, input logic [2:0] step,
                                             input logic [7:0] rg, input logic [7:0] val);
      logic [10:0] w;
      w = {CMD_STOP, 8'h00};
      if (!rw) begin
         case (step)
            3'd0:    w = {CMD_START, 8'h00};
            3'd1:    w = {CMD_WR, DEV_ADDR, 1'b0};
            3'd2:    w = {CMD_WR, rg};
            3'd3:    w = {CMD_WR, val};
            default: w = {CMD_STOP, 8'h00};
         endcase
      end else begin
         case (step)
            3'd0:    w = {CMD_START, 8'h00};
            3'd1:    w = {CMD_WR, DEV_ADDR, 1'b0};
            3'd2:    w = {CMD_WR, rg};
`ifdef I2C_SCCB_STOP_EN
            3'd3:    w = {CMD_STOP, 8'h00};
            3'd4:    w = {CMD_START, 8'h00};
            3'd5:    w = {CMD_WR, DEV_ADDR, 1'b1};
            3'd6:    w = {CMD_RD, 8'h01};
`else
            3'd3:    w = {CMD_RESTART, 8'h00};
            3'd4:    w = {CMD_WR, DEV_ADDR, 1'b1};
            3'd5:    w = {CMD_RD, 8'h01};
`endif
            default: w = {CMD_STOP, 8'h00};
         endcase
      end
      return w;
   endfunction

   assign w_step_word   = step_word(r_rw, r_step, r_reg, r_val);
   assign w_last        = r_rw ? RD_LAST : WR_LAST;
   assign w_is_wr       = (w_step_word[10:8] == CMD_WR);
   assign w_is_rd       = (w_step_word[10:8] == CMD_RD);
   // The master may raise m_ready in the same cycle as m_done_tick, so fold in the live ack.
   assign w_nack_now    = w_is_wr & (r_ack_cap | (m_done_tick & m_ack));
   assign w_settle_done = ((r_cnt + 16'd1) >= SETTLE_CYC);
   assign w_dly_done    = (r_cnt >= INIT_DLY);
   assign w_tbl_end     = (r_tbl_addr == {TBL_AW{1'b1}});
   assign w_sentinel    = (tbl_data == 16'hFFFF);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_DLY;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_DLY:     if (w_dly_done) w_state_nxt = S_FETCH;
         S_FETCH:   w_state_nxt = S_FETCH_W;
         S_FETCH_W: w_state_nxt = w_sentinel ? S_IDLE : S_ISSUE;
         S_ISSUE:   if (m_ready) w_state_nxt = S_GUARD;
         S_GUARD:   if (r_cnt[0]) w_state_nxt = S_WAIT;
         S_WAIT:    if (m_ready) w_state_nxt = (r_step == w_last) ? S_SETTLE : S_ISSUE;
         S_SETTLE:  if (w_settle_done) w_state_nxt = (r_host || w_tbl_end) ? S_IDLE : S_FETCH;
         S_IDLE:    if (req) w_state_nxt = S_ISSUE;
         default:   w_state_nxt = S_DLY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_step      <= '0;
         r_host      <= 1'b0;
         r_err       <= 1'b0;
         r_ack_cap   <= 1'b0;
         r_rdata     <= '0;
         r_tbl_addr  <= '0;
         r_m_cmd     <= '0;
         r_m_din     <= '0;
         r_m_wr      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_init_done <= 1'b0;
         r_init_err  <= 1'b0;
      end else begin
         r_m_wr      <= 1'b0;
         r_rsp_valid <= 1'b0;
         if (w_state_nxt != r_state) r_cnt <= '0;
         else                        r_cnt <= r_cnt + 16'd1;
         case (r_state)
            S_FETCH_W: begin
               r_host <= 1'b0;
               r_step <= '0;
               r_err  <= 1'b0;
               if (w_sentinel) r_init_done <= 1'b1;
            end
            S_ISSUE: if (m_ready) begin
               r_m_wr    <= 1'b1;
               r_m_cmd   <= w_step_word[10:8];
               r_m_din   <= w_step_word[7:0];
               r_ack_cap <= 1'b0;
            end
            S_WAIT: begin
               if (m_done_tick) r_ack_cap <= m_ack;
               if (m_done_tick && w_is_rd) r_rdata <= m_dout;
               if (m_ready && (r_step != w_last)) r_step <= w_nack_now ? w_last : r_step + 3'd1;
               if (m_ready && w_nack_now) begin
                  r_err <= 1'b1;
                  if (!r_host) r_init_err <= 1'b1;
               end
            end
            S_SETTLE: if (w_settle_done) begin
               if (r_host) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= r_err;
                  r_rsp_rdata <= r_err ? 8'h00 : r_rdata;
               end else if (w_tbl_end) begin
                  r_init_done <= 1'b1;
               end else begin
                  r_tbl_addr <= r_tbl_addr + {{(TBL_AW-1){1'b0}}, 1'b1};
               end
            end
            S_IDLE: if (req) begin
               r_host  <= 1'b1;
               r_step  <= '0;
               r_err   <= 1'b0;
               r_rdata <= '0;
            end
            default: ;
         endcase
      end
   end

   // Transaction operands: table entry or registered host request.
   always_ff @(posedge clk) begin
      if (r_state == S_FETCH_W) begin
         r_rw  <= 1'b0;
         r_reg <= tbl_data[15:8];
         r_val <= tbl_data[7:0];
      end else if ((r_state == S_IDLE) && req) begin
         r_rw  <= req_rw;
         r_reg <= req_reg;
         r_val <= req_wdata;
      end
   end

   assign m_cmd     = r_m_cmd;
   assign m_din     = r_m_din;
   assign m_wr      = r_m_wr;
   assign tbl_addr  = r_tbl_addr;
   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign init_done = r_init_done;
   assign init_err  = r_init_err;
endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

- Sequences the I2C byte-level master to configure an attached image sensor over I2C/SCCB for the Sobel pipeline.
- After reset, walks a register table of {reg, value} pairs and issues one register-write transaction per entry.
- Then serves single-register read/write requests from the host side.
- Issues only START/WR/RD/STOP/RESTART commands to the master and checks slave ACKs.

## Interface
Parameters:
- DEV_ADDR, 7'h21, 7-bit slave address.
- INIT_DLY, 16'd1000, cycles to wait after reset before the first table fetch.
- SETTLE_CYC, 16'd100, idle cycles inserted after every completed transaction.
- TBL_AW, 8, table address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_cmd  out  3  master command (000 START, 001 WR, 010 RD, 011 STOP, 100 RESTART).
- m_din  out  8  master byte; for RD, bit0=1 requests NACK.
- m_wr  out  1  one-cycle command strobe.
- m_ready  in  1  master ready.
- m_done_tick  in  1  byte complete.
- m_ack  in  1  slave ack bit; 0=ACK, 1=NACK.
- m_dout  in  8  received byte.
- tbl_addr  out  TBL_AW  table address.
- tbl_data  in  16  {reg[15:8], val[7:0]}; synchronous ROM, valid one cycle after tbl_addr.
- req  in  1  host request.
- req_rw  in  1  1=read, 0=write.
- req_reg  in  8  register address.
- req_wdata  in  8  write data.
- req_ready  out  1  high when a request can be accepted.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data.
- rsp_err  out  1  NACK seen; valid with rsp_valid.
- init_done  out  1  table finished; sticky.
- init_err  out  1  any table entry NACKed; sticky.

## Operation
- States: DLY, FETCH, FETCH_W, ISSUE, GUARD, WAIT, SETTLE, IDLE.
- Reset sequence:
  - DLY counts to INIT_DLY, then enters FETCH.
  - FETCH drives tbl_addr. FETCH_W latches tbl_data.
  - tbl_data == 16'hFFFF terminates the table: set init_done and go to IDLE.
  - Otherwise build the write step list and enter ISSUE.
- Write step list: START, WR {DEV_ADDR,0}, WR reg, WR val, STOP.
- Read step list: START, WR {DEV_ADDR,0}, WR reg, RESTART, WR {DEV_ADDR,1}, RD 8'h01, STOP.
- ISSUE: when m_ready=1, drive m_cmd/m_din and pulse m_wr for exactly one cycle, then enter GUARD.
- GUARD: hold 2 cycles, ignoring m_ready, then enter WAIT.
- WAIT:
  - For WR/RD steps, capture m_ack/m_dout on m_done_tick.
  - Advance to the next step when m_ready=1.
- NACK on any WR step:
  - Skip all remaining steps except a final STOP.
  - Flag the error.
  - For a table entry, set init_err and continue with the next entry.
- After STOP completes: SETTLE counts SETTLE_CYC cycles. Then:
  - table mode: increment tbl_addr and go to FETCH;
  - host mode: pulse rsp_valid and go to IDLE.
- rsp_rdata: m_dout captured at the RD step, or 0 on error.
- req_ready = (state==IDLE). A request is accepted on req && req_ready; req_rw/req_reg/req_wdata are registered on acceptance.
- req during init is ignored, not queued.
- tbl_addr wraps at 2^TBL_AW-1: after the last address, set init_done without a sentinel.
- Reset mid-transaction: everything returns to reset values immediately. The master is reset by the same reset_n, so no STOP is emitted.

## Timing
- Reset values:
  - state DLY; all counters 0;
  - m_cmd=0, m_din=0, m_wr=0;
  - tbl_addr=0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - init_done=0, init_err=0.
- m_wr is registered and never high on two consecutive cycles. Minimum spacing between strobes is 4 cycles.
- rsp_valid is registered: asserted on the cycle after SETTLE expires; req_ready rises the same cycle.
- Table fetch latency: 2 cycles per entry (FETCH, FETCH_W).

## Configuration
- I2C_SCCB_STOP_EN:
  - Defined: read sequences replace RESTART with STOP then START, giving START, WR addrW, WR reg, STOP, START, WR addrR, RD, STOP. This is required for OV-series SCCB sensors.
  - Undefined: repeated-start RESTART is used.

## Test plan
- Table {12 80}, {11 01}, FFFF with an always-ACK slave model -> two 5-command write sequences (bytes 42,12,80 then 42,11,01); init_done=1, init_err=0; tbl_addr stops at 2.
- Slave NACKs the reg byte of entry 0 -> STOP issued immediately after that WR, no value byte sent; init_err=1; entry 1 still written.
- Host read of reg 0x0A, slave returns 0x76 -> one rsp_valid pulse, rsp_rdata=0x76, rsp_err=0; RD issued with m_din=0x01; command order matches the I2C_SCCB_STOP_EN setting.
- Host write of reg 0x40 = 0xD0 with req held high -> accepted once; req_ready low until rsp_valid.
- reset_n asserted during WAIT of a WR step -> all outputs at reset values the same cycle; after release, DLY restarts and tbl_addr=0.
- Table with no sentinel and TBL_AW=2 -> 4 entries written, then init_done=1.
